// File: rtl/fpm_pkg.sv
// Shared types and defaults for the FP multiplier arbiter slice.
package fpm_pkg;

  localparam int unsigned FP_WIDTH        = 32;
  localparam int unsigned MUL_LATENCY_DEF = 2;
  localparam int unsigned RSP_DEPTH_DEF   = 4;
  localparam int unsigned ID_WIDTH        = 1;

  typedef logic [ID_WIDTH-1:0] id_t;

  typedef struct packed {
    logic valid;
    id_t  id;
  } tag_t;

  typedef struct packed {
    id_t                 id;
    logic [FP_WIDTH-1:0] result;
    logic                of;
  } rsp_t;

  localparam int unsigned RSP_WIDTH = $bits(rsp_t);

endpackage

// File: rtl/fpm_rsp_fifo.sv
// Synchronous response FIFO; simultaneous push and pop is legal even when full.
module fpm_rsp_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             full, do_pop, do_push;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign valid   = (cnt_q != '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign do_pop  = pop && valid;
  // When full, a push is only taken if the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= next_ptr(wptr_q);
      end
      if (do_pop) rptr_q <= next_ptr(rptr_q);
      if (do_push && !do_pop) cnt_q <= cnt_q + CNT_W'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/fpm_arbiter.sv
// Round-robin arbiter sharing one pipelined FP multiplier between two requesters,
// with tagged in-order response buffering and credit-based flow control.
module fpm_arbiter
  import fpm_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEF,
  parameter int unsigned RSP_DEPTH   = RSP_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  input  logic                req1_valid,
  output logic                req0_ready,
  output logic                req1_ready,
  input  logic [FP_WIDTH-1:0] req0_a,
  input  logic [FP_WIDTH-1:0] req0_b,
  input  logic [FP_WIDTH-1:0] req1_a,
  input  logic [FP_WIDTH-1:0] req1_b,
  output logic                mul_en,
  output logic [FP_WIDTH-1:0] mul_a,
  output logic [FP_WIDTH-1:0] mul_b,
  input  logic [FP_WIDTH-1:0] mul_result,
  input  logic                mul_of,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output id_t                 rsp_id,
  output logic [FP_WIDTH-1:0] rsp_result,
  output logic                rsp_of,
  output logic                busy
);

  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

  logic                mul_en_q;
  id_t                 ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [FP_WIDTH-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  tag_t                tag_q [MUL_LATENCY];
  logic                issue, rsp_pop;
  id_t                 issue_id;
  rsp_t                push_data, rsp_data;

  // Credit uses the registered count only, so a pop frees a slot one cycle later.
  always_comb begin
    issue    = 1'b0;
    issue_id = '0;
    if (mul_en_q && (cnt_q < CNT_W'(RSP_DEPTH))) begin
      if (req0_valid && req1_valid) begin
        issue    = 1'b1;
        issue_id = ptr_q;
      end else if (req0_valid) begin
        issue    = 1'b1;
        issue_id = id_t'(0);
      end else if (req1_valid) begin
        issue    = 1'b1;
        issue_id = id_t'(1);
      end
    end
  end

  assign req0_ready = issue && (issue_id == id_t'(0));
  assign req1_ready = issue && (issue_id == id_t'(1));
  assign rsp_pop    = rsp_valid && rsp_ready;

  always_comb begin
    ptr_d   = ptr_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    cnt_d   = cnt_q;
    if (issue) begin
      ptr_d   = ~issue_id;
      mul_a_d = (issue_id == id_t'(1)) ? req1_a : req0_a;
      mul_b_d = (issue_id == id_t'(1)) ? req1_b : req0_b;
    end
    case ({issue, rsp_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_en_q <= 1'b0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
    end else begin
      mul_en_q <= 1'b1;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
    end
  end

  // Tag pipeline mirrors the multiplier so the result is captured with its requester id.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MUL_LATENCY); i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{valid: issue, id: issue_id};
      for (int i = 1; i < int'(MUL_LATENCY); i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign push_data = '{id: tag_q[MUL_LATENCY-1].id, result: mul_result, of: mul_of};

  fpm_rsp_fifo #(
    .WIDTH (RSP_WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tag_q[MUL_LATENCY-1].valid),
    .wdata (push_data),
    .pop   (rsp_pop),
    .rdata (rsp_data),
    .valid (rsp_valid)
  );

  assign mul_en     = mul_en_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign rsp_id     = rsp_data.id;
  assign rsp_result = rsp_data.result;
  assign rsp_of     = rsp_data.of;
  assign busy       = (cnt_q != '0);

endmodule

// File: tb/tb_fpm_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_fpm_arbiter;

  localparam int L = 2;
  localparam int D = 4;

  logic        clk, rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready, rsp_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        mul_en, mul_of, rsp_valid, rsp_of, busy;
  logic [31:0] mul_a, mul_b, mul_result, rsp_result;
  logic [0:0]  rsp_id;

  int vectors = 0;
  int miscompares = 0;

  fpm_arbiter #(
    .MUL_LATENCY (L),
    .RSP_DEPTH   (D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .mul_en     (mul_en),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .mul_of     (mul_of),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_of     (rsp_of),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Truncating single-precision multiply for normal operands; returns {overflow, result}.
  function automatic logic [32:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          e;
    logic [47:0] m;
    logic [22:0] f;
    s = a[31] ^ b[31];
    m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (m[47]) begin
      f = m[46:24];
      e = e + 1;
    end else begin
      f = m[45:23];
    end
    if (e >= 255) return {1'b1, s, 8'hFF, 23'h0};
    if (e <= 0) return {1'b0, s, 31'h0};
    return {1'b0, s, e[7:0], f};
  endfunction

  // External multiplier: operands registered by the DUT, one more stage here.
  logic [32:0] mul_pipe;
  always_ff @(posedge clk) mul_pipe <= fp_mul(mul_a, mul_b);
  assign mul_result = mul_pipe[31:0];
  assign mul_of     = mul_pipe[32];

  typedef struct {
    logic        id;
    logic [32:0] res;
    int          avail;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  logic        mptr = 1'b0;
  logic        live = 1'b0;
  logic [31:0] last_a = '0, last_b = '0;
  logic [31:0] last_rsp = '0;
  int          acc0 = 0;
  int          of1_seen = 0;
  logic        glog[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rand_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  // One clock: check outputs at the falling edge against the model, then advance the model.
  task automatic tick();
    logic g, gid, exp_v;
    @(negedge clk);
    g   = 1'b0;
    gid = 1'b0;
    if (live && q.size() < D) begin
      if (req0_valid && req1_valid) begin
        g   = 1'b1;
        gid = mptr;
      end else if (req0_valid) begin
        g = 1'b1;
      end else if (req1_valid) begin
        g   = 1'b1;
        gid = 1'b1;
      end
    end
    exp_v = (q.size() > 0) && (q[0].avail <= cyc);
    chk("req0_ready", 32'(req0_ready), 32'(g && !gid));
    chk("req1_ready", 32'(req1_ready), 32'(g && gid));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
    chk("busy", 32'(busy), 32'(q.size() != 0));
    chk("mul_en", 32'(mul_en), 32'(live));
    chk("mul_a", mul_a, last_a);
    chk("mul_b", mul_b, last_b);
    if (exp_v) begin
      chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
      chk("rsp_result", rsp_result, q[0].res[31:0]);
      chk("rsp_of", 32'(rsp_of), 32'(q[0].res[32]));
    end
    if (req0_ready === 1'b1) glog.push_back(1'b0);
    else if (req1_ready === 1'b1) glog.push_back(1'b1);
    @(posedge clk);
    cyc++;
    live = 1'b1;
    if (exp_v && rsp_ready) begin
      last_rsp = rsp_result;
      if (rsp_of === 1'b1 && rsp_id === 1'b1) of1_seen++;
      void'(q.pop_front());
    end
    if (g) begin
      last_a = gid ? req1_a : req0_a;
      last_b = gid ? req1_b : req0_b;
      q.push_back('{gid, fp_mul(last_a, last_b), cyc + L});
      mptr = !gid;
      if (!gid) acc0++;
    end
    #1;
  endtask

  task automatic idle(input int n);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic model_reset();
    q.delete();
    mptr   = 1'b0;
    live   = 1'b0;
    last_a = '0;
    last_b = '0;
  endtask

  initial begin
    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rsp_ready  = 1'b1;
    req0_a     = 32'h3F80_0000;
    req0_b     = 32'h4000_0000;
    req1_a     = 32'h4040_0000;
    req1_b     = 32'h4080_0000;
    #1;
    chk("rst_mul_en", 32'(mul_en), 32'd0);
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(req1_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_of", 32'(rsp_of), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mul_a", mul_a, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Both requesters streaming: grants alternate starting at requester 0.
    glog.delete();
    for (int i = 0; i < 6; i++) begin
      req0_a = rand_fp(); req0_b = rand_fp();
      req1_a = rand_fp(); req1_b = rand_fp();
      tick();
    end
    chk("rr_grants", 32'(glog.size()), 32'd5);
    if (glog.size() >= 4) begin
      chk("rr_g0", 32'(glog[0]), 32'd0);
      chk("rr_g1", 32'(glog[1]), 32'd1);
      chk("rr_g2", 32'(glog[2]), 32'd0);
      chk("rr_g3", 32'(glog[3]), 32'd1);
    end
    idle(10);

    // Directed product with known result.
    req0_valid = 1'b1;
    req0_a     = 32'h4201_9999;
    req0_b     = 32'h4124_CCCC;
    tick();
    req0_valid = 1'b0;
    idle(6);
    chk("known_product", 32'((last_rsp >= 32'h43A6_DC27) && (last_rsp <= 32'h43A6_DC29)), 32'd1);

    // Consumer stalled: only RSP_DEPTH operations accepted, then drain in order.
    acc0       = 0;
    rsp_ready  = 1'b0;
    req0_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req0_a = rand_fp(); req0_b = rand_fp();
      tick();
    end
    chk("stall_accepted", 32'(acc0), 32'd4);
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req0_a = rand_fp(); req0_b = rand_fp();
      tick();
    end
    idle(10);

    // Overflowing op from requester 1 between two normal ones.
    of1_seen   = 0;
    req1_valid = 1'b1;
    req1_a = 32'h3FC0_0000; req1_b = 32'h4000_0000; tick();
    req1_a = 32'h7F00_0000; req1_b = 32'h7F00_0000; tick();
    req1_a = 32'h4040_0000; req1_b = 32'h3F00_0000; tick();
    idle(8);
    chk("of_count", 32'(of1_seen), 32'd1);

    // Reset with operations in flight discards them.
    rsp_ready  = 1'b0;
    req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req0_a = rand_fp(); req0_b = rand_fp();
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_mul_en", 32'(mul_en), 32'd0);
    chk("midrst_req0_ready", 32'(req0_ready), 32'd0);
    chk("midrst_mul_a", mul_a, 32'd0);
    model_reset();
    req0_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(8);

    // Random traffic with back-pressure.
    for (int i = 0; i < 400; i++) begin
      req0_valid = ($urandom_range(0, 99) < 60);
      req1_valid = ($urandom_range(0, 99) < 60);
      rsp_ready  = ($urandom_range(0, 99) < 70);
      req0_a = rand_fp(); req0_b = rand_fp();
      req1_a = rand_fp(); req1_b = rand_fp();
      tick();
    end
    idle(12);
    chk("final_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
